audio_refill_ctrl: RTL and testbench
====================================

AUDIO_REFILL_CTRL -- requirements
Module: audio_refill_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 256: words fetched per refill burst.
REQ-002 Parameter REFILL_LEVEL, default 1536: a burst is started when fifo_wrusedw < REFILL_LEVEL; REFILL_LEVEL + BURST_LEN <= 2048.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high (clk, reset).
REQ-004 clk  in  1  50 MHz system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse: begin playback at track_base.
REQ-007 stop  in  1  one-cycle pulse: end playback.
REQ-008 loop_en  in  1  restart at track_base when the track ends.
REQ-009 track_base  in  25  SDRAM word address of the first sample.
REQ-010 track_len  in  25  track length in 16-bit words.
REQ-011 sdram_rd  out  1  read request to the SDRAM arbiter port.
REQ-012 sdram_addr  out  25  word address of the current request.
REQ-013 sdram_ac  in  1  one-cycle acknowledge; sdram_data is valid in the same cycle.
REQ-014 sdram_data  in  16  read data.
REQ-015 fifo_wrreq  out  1  write strobe to the audio FIFO.
REQ-016 fifo_data  out  16  FIFO write data.
REQ-017 fifo_wrusedw  in  11  FIFO fill level, write-clock domain.
REQ-018 fifo_wrfull  in  1  FIFO full.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at the end of the track when loop_en=0.
REQ-021 overflow  out  1  sticky flag: an acknowledged word was dropped.

Function
REQ-022 The FSM has the states IDLE, CHECK, REQ, NEXT.
  - IDLE->CHECK on start.
  - CHECK->REQ when fifo_wrusedw < REFILL_LEVEL.
  - REQ->NEXT on sdram_ac.
  - NEXT->REQ while burst words and track words remain.
  - NEXT->CHECK when the burst is complete.
REQ-023 sdram_rd is high only in REQ; sdram_addr stays stable from REQ entry until sdram_ac.
REQ-024 sdram_rd is low for exactly one cycle (NEXT) between consecutive requests.
REQ-025 On sdram_ac with fifo_wrfull=0:
  - fifo_wrreq pulses in the next cycle;
  - fifo_data equals the sdram_data captured on sdram_ac.
REQ-026 On sdram_ac with fifo_wrfull=1: the word is dropped, fifo_wrreq stays low, and overflow is set.
REQ-027 sdram_addr = track_base + position; position increments by 1 per sdram_ac; the addition is 25-bit.
REQ-028 End of track, when position reaches track_len in NEXT:
  - loop_en=1: position returns to 0 and the FSM goes to CHECK;
  - loop_en=0: done pulses and the FSM goes to IDLE.
REQ-029 start with track_len=0: done pulses one cycle later, no request is issued, and the FSM stays IDLE.
REQ-030 stop in IDLE, CHECK or NEXT: the FSM goes to IDLE next cycle, with no done pulse.
REQ-031 stop in REQ: the FSM waits for sdram_ac, writes that word, then goes to IDLE; the bus transaction is never abandoned.
REQ-032 start while busy is ignored; start and stop in the same cycle: stop wins.
REQ-033 track_base and track_len are latched on start; later changes take effect only on the next start.

Reset
REQ-034 Reset puts the FSM in IDLE and clears position and the burst counter.
REQ-035 Output reset values: sdram_rd=0, sdram_addr=0, fifo_wrreq=0, fifo_data=0, busy=0, done=0, overflow=0.
REQ-036 Reset during REQ drops sdram_rd on the next cycle; the arbiter tolerates request withdrawal under global reset.

Structure
REQ-037 The shared package holds:
  - the state enum;
  - the BURST_LEN and REFILL_LEVEL defaults;
  - the 25-bit SDRAM word-address typedef.
REQ-038 The block is a single module with no sub-modules; position and burst counters are inline.

Verification
REQ-039 Burst: track_base=0x100, track_len=1000, fifo_wrusedw=0, arbiter acks after 3 cycles -> exactly 256 requests at addresses 0x100..0x1FF, 256 FIFO writes with matching data, then CHECK.
REQ-040 Hold-off: fifo_wrusedw=1536 -> no sdram_rd; drop it to 1535 -> sdram_rd rises within 2 cycles.
REQ-041 End of track: track_len=300, loop_en=0 -> 300 writes, done pulse, busy=0; with loop_en=1 -> the 301st request is at track_base.
REQ-042 Stop mid-REQ: stop while waiting, ack 5 cycles later -> 1 final FIFO write, then IDLE, no done, no further sdram_rd.
REQ-043 Overflow: fifo_wrfull=1 at ack -> no fifo_wrreq, overflow=1 and held until reset.
REQ-044 Edge cases: track_len=0 -> done pulse with zero requests; start and stop in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/audio_refill_ctrl_pkg.sv
// audio_refill_ctrl_pkg: shared state type, defaults and address type for the audio refill controller
package audio_refill_ctrl_pkg;
  localparam int BURST_LEN_DEF = 256;
  localparam int REFILL_LEVEL_DEF = 1536;
  typedef logic [24:0] sdram_addr_t;
  typedef enum logic [1:0] {IDLE, CHECK, REQ, NEXT} state_t;
endpackage

// File: rtl/audio_refill_ctrl_if.sv
// audio_refill_ctrl_if: SDRAM read port and audio FIFO write port of the refill controller
interface audio_refill_ctrl_if
  import audio_refill_ctrl_pkg::*;
;
  logic sdram_rd;
  sdram_addr_t sdram_addr;
  logic sdram_ac;
  logic [15:0] sdram_data;
  logic fifo_wrreq;
  logic [15:0] fifo_data;
  logic [10:0] fifo_wrusedw;
  logic fifo_wrfull;
  modport master (
    output sdram_rd, sdram_addr, fifo_wrreq, fifo_data,
    input sdram_ac, sdram_data, fifo_wrusedw, fifo_wrfull
  );
  modport slave (
    input sdram_rd, sdram_addr, fifo_wrreq, fifo_data,
    output sdram_ac, sdram_data, fifo_wrusedw, fifo_wrfull
  );
endinterface

// File: rtl/audio_refill_ctrl.sv
// audio_refill_ctrl: streams a track from SDRAM into the audio FIFO in bursts, refilling below a fill level
module audio_refill_ctrl
  import audio_refill_ctrl_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int REFILL_LEVEL = REFILL_LEVEL_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic loop_en,
  input  sdram_addr_t track_base,
  input  sdram_addr_t track_len,
  output logic busy,
  output logic done,
  output logic overflow,
  audio_refill_ctrl_if.master bus
);
  localparam int BW = $clog2(BURST_LEN + 1);
  state_t state, state_n;
  sdram_addr_t base, len, pos;
  logic [BW-1:0] burst;
  logic stop_pend, ack, go, track_end, burst_end;
  assign go = state == IDLE && start && !stop;
  assign ack = state == REQ && bus.sdram_ac;
  assign track_end = pos == len;
  assign burst_end = burst == BW'(BURST_LEN);
  assign bus.sdram_rd = state == REQ;
  assign bus.sdram_addr = base + pos;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go && track_len != '0 ? CHECK : IDLE;
      CHECK:   state_n = stop ? IDLE : {1'b0, bus.fifo_wrusedw} < 12'(REFILL_LEVEL) ? REQ : CHECK;
      REQ:     state_n = !ack ? REQ : stop || stop_pend ? IDLE : NEXT;
      NEXT:    state_n = stop ? IDLE : track_end ? (loop_en ? CHECK : IDLE) : burst_end ? CHECK : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // a stop seen in REQ is remembered so the pending bus read still completes
  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
      len <= '0;
      pos <= '0;
      burst <= '0;
      stop_pend <= 1'b0;
      bus.fifo_wrreq <= 1'b0;
      bus.fifo_data <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bus.fifo_wrreq <= ack && !bus.fifo_wrfull;
      overflow <= overflow || (ack && bus.fifo_wrfull);
      done <= (go && track_len == '0) || (state == NEXT && !stop && track_end && !loop_en);
      stop_pend <= state == REQ && !ack && (stop_pend || stop);
      if (ack && !bus.fifo_wrfull) bus.fifo_data <= bus.sdram_data;
      if (go) begin
        base <= track_base;
        len <= track_len;
        pos <= '0;
        burst <= '0;
      end else if (ack) begin
        pos <= pos + 25'd1;
        burst <= burst + BW'(1);
      end else if (state == NEXT && state_n == CHECK) begin
        burst <= '0;
        pos <= track_end ? '0 : pos;
      end
    end
  end
endmodule

// File: tb/tb_audio_refill_ctrl.sv
// tb_audio_refill_ctrl: random-latency SDRAM arbiter and FIFO scoreboard around audio_refill_ctrl
module tb_audio_refill_ctrl;
  import audio_refill_ctrl_pkg::*;
  logic clk = 0, reset = 1, start = 0, stop = 0, loop_en = 0;
  sdram_addr_t track_base = '0, track_len = '0;
  logic busy, done, overflow;
  audio_refill_ctrl_if bus();
  audio_refill_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .track_base(track_base), .track_len(track_len),
    .busy(busy), .done(done), .overflow(overflow), .bus(bus)
  );
  always #10 clk = ~clk;
  int n_chk = 0, n_err = 0;
  int n_ack = 0, n_wr = 0, n_done = 0, n_rise = 0, n_rdcyc = 0, cyc = 0, t_first = 0, t_last = 0;
  int ack_dly = 3, cur_dly = 0, wait_cnt = 0, m_len = 1;
  bit dly_rand = 0, ac_prev = 0, prev_rd = 0;
  sdram_addr_t m_base = '0, prev_addr = '0, last_addr = '0;
  logic [15:0] salt;
  logic [15:0] exp_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] mem(input sdram_addr_t a);
    return a[15:0] ^ {a[24:16], a[6:0]} ^ salt;
  endfunction
  // sdram arbiter with programmable latency plus fifo scoreboard
  initial begin
    sdram_addr_t exp_a;
    bus.sdram_ac = 0;
    bus.sdram_data = '0;
    bus.fifo_wrusedw = '0;
    bus.fifo_wrfull = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_wrreq) begin
        n_wr++;
        if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("fifo_data", bus.fifo_data, exp_q.pop_front());
      end
      if (done) n_done++;
      if (ac_prev) chk("rd_gap", bus.sdram_rd, 0);
      if (bus.sdram_rd && prev_rd) chk("addr_hold", bus.sdram_addr, prev_addr);
      if (bus.sdram_rd) n_rdcyc++;
      if (bus.sdram_rd && !prev_rd) n_rise++;
      prev_rd = bus.sdram_rd;
      prev_addr = bus.sdram_addr;
      ac_prev = 0;
      bus.sdram_ac = 0;
      if (!bus.sdram_rd || reset) begin
        wait_cnt = 0;
        cur_dly = dly_rand ? int'($urandom_range(0, 3)) : ack_dly;
      end else if (wait_cnt < cur_dly) begin
        wait_cnt++;
      end else begin
        exp_a = m_base + 25'(n_ack % m_len);
        chk("req_addr", bus.sdram_addr, exp_a);
        bus.sdram_ac = 1;
        bus.sdram_data = mem(bus.sdram_addr);
        ac_prev = 1;
        if (!bus.fifo_wrfull) exp_q.push_back(mem(exp_a));
        last_addr = bus.sdram_addr;
        n_ack++;
        if (n_ack == 1) t_first = cyc;
        t_last = cyc;
      end
    end
  end
  task automatic start_track(input sdram_addr_t b, input int len, input logic lp);
    track_base = b;
    track_len = 25'(len);
    loop_en = lp;
    start = 1;
    m_base = b;
    m_len = len == 0 ? 1 : len;
    n_ack = 0; n_wr = 0; n_done = 0; n_rise = 0; n_rdcyc = 0;
    @(negedge clk);
    start = 0;
    track_base = 25'($urandom);
    track_len = 25'($urandom);
  endtask
  task automatic wait_acks(input int n, input int lim);
    int k = 0;
    while (n_ack < n && k < lim) begin @(negedge clk); k++; end
    chk("wait_acks", n_ack, n);
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin @(negedge clk); k++; end
    chk("wait_idle", busy, 0);
  endtask
  task automatic wait_rd(input int lim);
    int k = 0;
    while (!bus.sdram_rd && k < lim) begin @(negedge clk); k++; end
    chk("wait_rd", bus.sdram_rd, 1);
  endtask
  initial begin
    sdram_addr_t b;
    int w, d, a, r, len;
    bit seen;
    salt = 16'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_rd", bus.sdram_rd, 0);
    chk("rst_addr", bus.sdram_addr, 0);
    chk("rst_wrreq", bus.fifo_wrreq, 0);
    chk("rst_data", bus.fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    reset = 0;
    @(negedge clk);
    // hold-off, then one full burst at fixed latency
    bus.fifo_wrusedw = 11'd1536;
    start_track(25'h100, 1000, 0);
    repeat (12) @(negedge clk);
    chk("holdoff_rd", n_rdcyc, 0);
    chk("holdoff_busy", busy, 1);
    bus.fifo_wrusedw = 11'd1535;
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= bus.sdram_rd; end
    chk("refill_rise", seen, 1);
    bus.fifo_wrusedw = 11'd1600;
    wait_acks(256, 4000);
    repeat (30) @(negedge clk);
    chk("burst_acks", n_ack, 256);
    chk("burst_writes", n_wr, 256);
    chk("burst_span", t_last - t_first, 255 * 5);
    chk("burst_last_addr", last_addr, 25'h1FF);
    chk("burst_check_rd", bus.sdram_rd, 0);
    chk("burst_busy", busy, 1);
    // stop while a request is outstanding
    ack_dly = 5;
    bus.fifo_wrusedw = '0;
    wait_rd(50);
    w = n_wr; d = n_done; a = n_ack;
    stop = 1;
    @(negedge clk);
    stop = 0;
    repeat (15) @(negedge clk);
    chk("stop_acks", n_ack, a + 1);
    chk("stop_final_write", n_wr, w + 1);
    chk("stop_idle", busy, 0);
    chk("stop_no_done", n_done, d);
    r = n_rise;
    repeat (20) @(negedge clk);
    chk("stop_no_rd", n_rise, r);
    chk("stop_q_empty", exp_q.size(), 0);
    // end of track across the 25-bit address wrap
    dly_rand = 1;
    b = 25'h1FFFF00 + 25'($urandom_range(0, 255));
    start_track(b, 300, 0);
    wait_idle(5000);
    repeat (5) @(negedge clk);
    chk("eot_acks", n_ack, 300);
    chk("eot_writes", n_wr, 300);
    chk("eot_done", n_done, 1);
    chk("eot_q_empty", exp_q.size(), 0);
    // looping track, with an ignored start while busy
    b = 25'($urandom);
    start_track(b, 300, 1);
    wait_acks(301, 5000);
    chk("loop_addr", last_addr, b);
    track_base = 25'($urandom);
    track_len = 25'd7;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_acks(320, 2000);
    stop = 1;
    @(negedge clk);
    stop = 0;
    wait_idle(100);
    repeat (5) @(negedge clk);
    chk("loop_no_done", n_done, 0);
    chk("loop_q_empty", exp_q.size(), 0);
    loop_en = 0;
    for (int i = 0; i < 4; i++) begin
      len = int'($urandom_range(1, 600));
      start_track(25'($urandom), len, 0);
      wait_idle(8000);
      repeat (5) @(negedge clk);
      chk("rand_acks", n_ack, len);
      chk("rand_writes", n_wr, len);
      chk("rand_done", n_done, 1);
    end
    // overflow is sticky until reset
    bus.fifo_wrfull = 1;
    start_track(25'($urandom), 3, 0);
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("ovf_writes", n_wr, 0);
    chk("ovf_flag", overflow, 1);
    bus.fifo_wrfull = 0;
    start_track(25'($urandom), 5, 0);
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("ovf_writes2", n_wr, 5);
    chk("ovf_sticky", overflow, 1);
    // zero-length track
    start_track(25'($urandom), 0, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    repeat (10) @(negedge clk);
    chk("zero_no_req", n_rise, 0);
    // start and stop together
    track_len = 25'd10;
    start = 1;
    stop = 1;
    @(negedge clk);
    start = 0;
    stop = 0;
    chk("startstop_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("startstop_no_req", n_rise, 0);
    chk("startstop_no_done", n_done, 1);
    // reset withdraws an outstanding request
    dly_rand = 0;
    ack_dly = 10;
    start_track(25'($urandom), 50, 0);
    wait_rd(20);
    reset = 1;
    @(negedge clk);
    chk("rstreq_rd", bus.sdram_rd, 0);
    chk("rstreq_busy", busy, 0);
    chk("rstreq_ovf", overflow, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
